// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Buffered 8N1 UART transmitter. Bytes arrive over a valid/ready handshake
// into a small FIFO and are serialised one start bit, eight data bits LSB
// first, one stop bit. The bit period matches the companion receiver's
// CLKS_PER_BIT convention, so both ends run at the same baud on one clock.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_TX_DV      byte-valid strobe; byte taken when i_TX_DV && o_TX_Ready
//   i_TX_Byte    byte to send, sampled on acceptance
//   o_TX_Ready   FIFO not full
//   o_TX_Serial  serial line, idles high
//   o_TX_Active  high from first start-bit cycle to last stop-bit cycle
//   o_TX_Done    one-cycle pulse after each frame's stop bit
//   o_FIFO_Count bytes currently buffered (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Serialiser state
    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic             frame_end_q, frame_end_d;
    logic             bit_end;

    // Registered line outputs
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             done_q,   done_d;

    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push = i_TX_DV && !fifo_full;
    assign pop  = (state_q == ST_IDLE) && !fifo_empty;

    assign bit_end = (clk_cnt_q == CLK_LAST);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_end_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    shift_d   = fifo_mem_q[rd_ptr_q];
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    clk_cnt_d   = '0;
                    state_d     = ST_IDLE;
                    frame_end_d = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // Line outputs follow the state one cycle later, so the first start-bit
    // cycle lands two edges after the byte is accepted and Done arrives in
    // the cycle right after the last stop cycle.
    always_comb begin
        case (state_q)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_q[bit_idx_q];
            default:  serial_d = 1'b1;
        endcase
        active_d = (state_q == ST_START) || (state_q == ST_DATA) ||
                   (state_q == ST_STOP);
        done_d   = frame_end_q;
    end

    // Storage needs no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= i_TX_Byte;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_end_q <= 1'b0;
            serial_q    <= 1'b1;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_end_q <= frame_end_d;
            serial_q    <= serial_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    assign o_TX_Ready   = !fifo_full;
    assign o_TX_Serial  = serial_q;
    assign o_TX_Active  = active_q;
    assign o_TX_Done    = done_q;
    assign o_FIFO_Count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A transaction-level model tracks which bytes the FIFO accepts and when
// frames start; a bench-side receiver decodes the serial line by sampling
// bit centres. Scenario tasks compare the DUT against both.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic       i_Clock   = 1'b0;
    logic       i_Rst_L   = 1'b1;
    logic       i_TX_DV   = 1'b0;
    logic [7:0] i_TX_Byte = 8'h00;
    logic       o_TX_Ready;
    logic       o_TX_Serial;
    logic       o_TX_Active;
    logic       o_TX_Done;
    logic [2:0] o_FIFO_Count;

    uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Rst_L     (i_Rst_L),
        .i_TX_DV     (i_TX_DV),
        .i_TX_Byte   (i_TX_Byte),
        .o_TX_Ready  (o_TX_Ready),
        .o_TX_Serial (o_TX_Serial),
        .o_TX_Active (o_TX_Active),
        .o_TX_Done   (o_TX_Done),
        .o_FIFO_Count(o_FIFO_Count)
    );

    always #5 i_Clock = ~i_Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents, accepted-byte scoreboard, frame timing
    int         edge_no       = 0;
    int         next_pop_edge = 0;
    logic [7:0] m_q  [$];
    logic [7:0] sb_q [$];

    // Bench receiver state
    logic [7:0] rx_q    [$];
    int         start_q [$];
    int         rx_phase  = -1;
    logic [7:0] rx_sh     = 8'h00;
    int         done_cnt  = 0;
    int         frame_err = 0;

    // A byte is accepted when fewer than DEPTH are buffered before the edge;
    // a frame starts one edge after the transmitter goes idle and spans
    // FRAME cycles, the next one able to start FRAME+1 edges later.
    task automatic model_edge();
        bit push_ok;
        edge_no++;
        if (i_Rst_L) begin
            push_ok = i_TX_DV && (m_q.size() < DEPTH);
            if (m_q.size() > 0 && edge_no >= next_pop_edge) begin
                void'(m_q.pop_front());
                next_pop_edge = edge_no + FRAME + 1;
            end
            if (push_ok) begin
                m_q.push_back(i_TX_Byte);
                sb_q.push_back(i_TX_Byte);
            end
        end
    endtask

    // Receiver: first low sample marks the start, then sample each bit centre.
    task automatic decode_sample();
        int slot;
        if (!i_Rst_L) begin
            rx_phase = -1;
        end else begin
            if (o_TX_Done === 1'b1) done_cnt++;
            if (rx_phase < 0) begin
                if (o_TX_Serial === 1'b0) begin
                    rx_phase = 0;
                    start_q.push_back(edge_no);
                end
            end else begin
                rx_phase++;
            end
            if (rx_phase >= 0 && (rx_phase % C) == (C / 2)) begin
                slot = rx_phase / C;
                if (slot == 0) begin
                    if (o_TX_Serial !== 1'b0) frame_err++;
                end else if (slot <= 8) begin
                    rx_sh[slot-1] = o_TX_Serial;
                end else begin
                    if (o_TX_Serial !== 1'b1) frame_err++;
                    else rx_q.push_back(rx_sh);
                    rx_phase = -1;
                end
            end
        end
    endtask

    // Drive inputs, let one rising edge happen, then sample on the falling edge.
    task automatic tick(input logic dv, input logic [7:0] b);
        i_TX_DV   = dv;
        i_TX_Byte = b;
        @(posedge i_Clock);
        model_edge();
        @(negedge i_Clock);
        decode_sample();
    endtask

    task automatic clear_queues();
        sb_q.delete();
        rx_q.delete();
        start_q.delete();
    endtask

    task automatic model_reset();
        m_q.delete();
        next_pop_edge = 0;
        clear_queues();
    endtask

    task automatic drain();
        int n = 0;
        while (!(m_q.size() == 0 && edge_no >= next_pop_edge + 2 &&
                 rx_q.size() >= sb_q.size()) && n < 2000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("[TB] FAIL drain_timeout received=%0d required=%0d", rx_q.size(), sb_q.size());
        end
    endtask

    task automatic test_reset();
        #2 i_Rst_L = 1'b0;
        #1;
        checks++;
        if ({o_TX_Serial, o_TX_Active, o_TX_Done, o_TX_Ready} !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL reset_outputs ser/act/done/rdy=%b required=1001",
                     {o_TX_Serial, o_TX_Active, o_TX_Done, o_TX_Ready});
        end
        checks++;
        if (o_FIFO_Count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_count got=%0d required=0", o_FIFO_Count);
        end
        repeat (3) tick(1'b0, 8'h00);
        model_reset();
        i_Rst_L = 1'b1;
        repeat (2) tick(1'b0, 8'h00);
        checks++;
        if ({o_TX_Serial, o_TX_Active} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL post_reset_idle ser/act=%b required=10", {o_TX_Serial, o_TX_Active});
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b = 8'h55;
        logic [2:0] exp_v;
        int         d0 = done_cnt;
        clear_queues();
        tick(1'b1, b);
        checks++;
        if (o_FIFO_Count !== 3'd1 || {o_TX_Serial, o_TX_Active, o_TX_Done} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL single_cycle0 count=%0d ser/act/done=%b required count=1 100",
                     o_FIFO_Count, {o_TX_Serial, o_TX_Active, o_TX_Done});
        end
        for (int k = 1; k <= 44; k++) begin
            tick(1'b0, 8'h00);
            exp_v = 3'b100;
            if (k >= 2 && k <= 5) exp_v[2] = 1'b0;
            else if (k >= 6 && k <= 37) exp_v[2] = b[(k-6)/4];
            if (k >= 2 && k <= 41) exp_v[1] = 1'b1;
            if (k == 42) exp_v[0] = 1'b1;
            checks++;
            if ({o_TX_Serial, o_TX_Active, o_TX_Done} !== exp_v) begin
                failures++;
                $display("[TB] FAIL single_wave cycle=%0d ser/act/done=%b required=%b",
                         k, {o_TX_Serial, o_TX_Active, o_TX_Done}, exp_v);
            end
            if (k == 1) begin
                checks++;
                if (o_FIFO_Count !== 3'd0 || o_TX_Ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL single_pop count=%0d ready=%b required 0 1", o_FIFO_Count, o_TX_Ready);
                end
            end
        end
        drain();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== b || done_cnt - d0 != 1) begin
            failures++;
            $display("[TB] FAIL single_decode frames=%0d done=%0d required 1 frame of %h, 1 done",
                     rx_q.size(), done_cnt - d0, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'hA5};
        int         d0 = done_cnt;
        int         e0 = frame_err;
        clear_queues();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, bytes[i]);
            checks++;
            if (o_FIFO_Count !== 3'(m_q.size())) begin
                failures++;
                $display("[TB] FAIL b2b_count push=%0d got=%0d required=%0d", i, o_FIFO_Count, m_q.size());
            end
        end
        drain();
        checks++;
        if (rx_q.size() != 3) begin
            failures++;
            $display("[TB] FAIL b2b_frames got=%0d required=3", rx_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (rx_q.size() > i) begin
                checks++;
                if (rx_q[i] !== bytes[i]) begin
                    failures++;
                    $display("[TB] FAIL b2b_byte idx=%0d got=%h required=%h", i, rx_q[i], bytes[i]);
                end
            end
        end
        for (int i = 1; i < 3; i++) begin
            if (start_q.size() > i) begin
                checks++;
                if (start_q[i] - start_q[i-1] != FRAME + 1) begin
                    failures++;
                    $display("[TB] FAIL b2b_spacing idx=%0d got=%0d required=%0d",
                             i, start_q[i] - start_q[i-1], FRAME + 1);
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 3 || frame_err != e0) begin
            failures++;
            $display("[TB] FAIL b2b_done done=%0d framing_errors=%0d required 3 and 0",
                     done_cnt - d0, frame_err - e0);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_b [5] = '{8'h77, 8'h01, 8'h02, 8'h03, 8'h04};
        int         d0 = done_cnt;
        int         exp_cnt;
        logic       exp_rdy;
        clear_queues();
        tick(1'b1, 8'h77);
        repeat (3) tick(1'b0, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 8'(k));
            exp_cnt = (k < 4) ? k : 4;
            exp_rdy = (k < 4);
            checks++;
            if (o_FIFO_Count !== 3'(exp_cnt) || o_TX_Ready !== exp_rdy) begin
                failures++;
                $display("[TB] FAIL full_flags push=%0d count=%0d ready=%b required %0d %b",
                         k, o_FIFO_Count, o_TX_Ready, exp_cnt, exp_rdy);
            end
        end
        drain();
        checks++;
        if (rx_q.size() != 5 || done_cnt - d0 != 5) begin
            failures++;
            $display("[TB] FAIL full_frames got=%0d done=%0d required 5 5", rx_q.size(), done_cnt - d0);
        end
        for (int i = 0; i < 5; i++) begin
            if (rx_q.size() > i) begin
                checks++;
                if (rx_q[i] !== exp_b[i]) begin
                    failures++;
                    $display("[TB] FAIL full_byte idx=%0d got=%h required=%h", i, rx_q[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        clear_queues();
        tick(1'b1, 8'hC3);
        tick(1'b1, 8'h3C);
        tick(1'b1, 8'h96);
        repeat (17) tick(1'b0, 8'h00);
        // Cycle 19 carries data bit 3 of 0xC3, which is a 0.
        checks++;
        if (o_TX_Serial !== 1'b0 || o_TX_Active !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midframe_bit3 ser/act=%b required=01", {o_TX_Serial, o_TX_Active});
        end
        #2 i_Rst_L = 1'b0;
        #1;
        checks++;
        if ({o_TX_Serial, o_TX_Active, o_TX_Done, o_TX_Ready} !== 4'b1001 || o_FIFO_Count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL midframe_reset ser/act/done/rdy=%b count=%0d required 1001 0",
                     {o_TX_Serial, o_TX_Active, o_TX_Done, o_TX_Ready}, o_FIFO_Count);
        end
        model_reset();
        repeat (2) tick(1'b0, 8'h00);
        i_Rst_L = 1'b1;
        for (int k = 0; k < 120; k++) begin
            tick(1'b0, 8'h00);
            if (o_TX_Serial !== 1'b1 || o_TX_Active !== 1'b0 || o_TX_Done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rx_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL midframe_quiet bad_cycles=%0d frames=%0d required 0 0", bad, rx_q.size());
        end
        tick(1'b1, 8'h5A);
        drain();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL midframe_recover frames=%0d required 1 frame of 5a", rx_q.size());
        end
    endtask

    task automatic test_loopback();
        int sent  = 0;
        int guard = 0;
        int mism  = 0;
        int first = -1;
        int d0    = done_cnt;
        int e0    = frame_err;
        clear_queues();
        while (sent < 256 && guard < 20000) begin
            if (m_q.size() < DEPTH) begin
                tick(1'b1, 8'($urandom));
                sent++;
            end else begin
                tick(1'b0, 8'h00);
            end
            guard++;
        end
        drain();
        checks++;
        if (rx_q.size() != 256 || sb_q.size() != 256) begin
            failures++;
            $display("[TB] FAIL loop_count received=%0d accepted=%0d required 256", rx_q.size(), sb_q.size());
        end
        for (int i = 0; i < sb_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== sb_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("[TB] FAIL loop_data wrong_bytes=%0d first_idx=%0d required 0", mism, first);
        end
        checks++;
        if (done_cnt - d0 != 256 || frame_err != e0) begin
            failures++;
            $display("[TB] FAIL loop_done done=%0d framing_errors=%0d required 256 0",
                     done_cnt - d0, frame_err - e0);
        end
    endtask

    task automatic test_stress();
        int bad   = 0;
        int first = -1;
        int mism  = 0;
        int d0    = done_cnt;
        int e0    = frame_err;
        clear_queues();
        for (int k = 0; k < 10000; k++) begin
            tick(1'($urandom_range(0, 1)), 8'($urandom));
            if (o_FIFO_Count !== 3'(m_q.size()) || o_FIFO_Count > 3'(DEPTH) ||
                o_TX_Ready !== (m_q.size() < DEPTH)) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL stress_flags bad_cycles=%0d first_cycle=%0d required 0", bad, first);
        end
        drain();
        checks++;
        if (rx_q.size() != sb_q.size()) begin
            failures++;
            $display("[TB] FAIL stress_count received=%0d required=%0d", rx_q.size(), sb_q.size());
        end
        for (int i = 0; i < sb_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== sb_q[i]) mism++;
        end
        checks++;
        if (mism != 0 || done_cnt - d0 != sb_q.size() || frame_err != e0) begin
            failures++;
            $display("[TB] FAIL stress_data wrong=%0d done=%0d framing_errors=%0d required 0 %0d 0",
                     mism, done_cnt - d0, frame_err - e0, sb_q.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
        test_loopback();
        test_stress();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
